// File: rtl/led_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : led_seq_pkg                                                       |
// | Brief  : Mode encodings and helpers shared by the LED step sequencer.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STEP_OWN = 2'b00,
        MODE_STEP_ANY = 2'b01,
        MODE_AUTO_FWD = 2'b10,
        MODE_AUTO_REV = 2'b11
    } seq_mode_e;

    function automatic logic is_auto(input seq_mode_e m);
        return m[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_sequencer_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : btn_debounce                                                      |
// | Brief  : 2-flop synchroniser, level debounce and one-cycle press pulse.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic stable,
    output logic press
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Falling stable edge only; releases are silent.
            r_press    <= r_stable_d & ~r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule
`default_nettype wire

// File: rtl/led_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : led_step_sequencer                                                |
// | Brief  : One-hot LED sequencer stepped by debounced buttons or a timer.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module led_step_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int AUTO_PERIOD     = 3000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           btn_n,
    input  logic [1:0]                mode,
    output logic [N_CH-1:0]           led,
    output logic [$clog2(N_CH)-1:0]   pos,
    output logic                      step_pulse,
    output logic                      paused
);

    localparam int c_pos_w = $clog2(N_CH);
    localparam int c_tmr_w = $clog2(AUTO_PERIOD);
    localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(N_CH - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(AUTO_PERIOD - 1);
    localparam logic [N_CH-1:0]    c_led_rst  = N_CH'(1);

    logic [N_CH-1:0]    w_stable_unused;
    logic [N_CH-1:0]    w_press;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn_n  (btn_n[gi]),
                .stable (w_stable_unused[gi]),
                .press  (w_press[gi])
            );
        end
    endgenerate

    seq_mode_e          r_mode;
    logic               r_started;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_paused;
    logic [c_pos_w-1:0] r_pos;
    logic [N_CH-1:0]    r_led;
    logic               r_step_pulse;

    seq_mode_e          w_mode_cur;
    logic               w_mode_chg;
    logic               w_any_press;
    logic               w_step;
    logic [c_tmr_w-1:0] w_timer_nxt;
    logic               w_paused_nxt;
    logic [c_pos_w-1:0] w_pos_fwd;
    logic [c_pos_w-1:0] w_pos_rev;
    logic [c_pos_w-1:0] w_pos_nxt;
    logic [N_CH-1:0]    w_led_nxt;

    always_comb begin
        w_mode_cur   = seq_mode_e'(mode);
        // The first cycle out of reset has no previous mode to compare against.
        w_mode_chg   = r_started && (w_mode_cur != r_mode);
        w_any_press  = |w_press;
        w_pos_fwd    = (r_pos == c_pos_last) ? '0 : r_pos + 1'b1;
        w_pos_rev    = (r_pos == '0) ? c_pos_last : r_pos - 1'b1;
        w_timer_nxt  = r_timer;
        w_paused_nxt = r_paused;
        w_step       = 1'b0;
        w_pos_nxt    = r_pos;

        if (w_mode_chg) begin
            w_timer_nxt  = '0;
            w_paused_nxt = 1'b0;
        end else if (is_auto(w_mode_cur)) begin
            if (w_any_press) begin
                w_paused_nxt = ~r_paused;
            end
            if (!r_paused) begin
                if (r_timer == c_tmr_last) begin
                    w_timer_nxt = '0;
                    w_step      = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            if (w_step) begin
                w_pos_nxt = (w_mode_cur == MODE_AUTO_REV) ? w_pos_rev : w_pos_fwd;
            end
        end else begin
            w_timer_nxt  = '0;
            w_paused_nxt = 1'b0;
            w_step       = (w_mode_cur == MODE_STEP_ANY) ? w_any_press : w_press[r_pos];
            if (w_step) begin
                w_pos_nxt = w_pos_fwd;
            end
        end

        w_led_nxt = c_led_rst << w_pos_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= MODE_STEP_OWN;
            r_started    <= 1'b0;
            r_timer      <= '0;
            r_paused     <= 1'b0;
            r_pos        <= '0;
            r_led        <= c_led_rst;
            r_step_pulse <= 1'b0;
        end else begin
            r_mode       <= w_mode_cur;
            r_started    <= 1'b1;
            r_timer      <= w_timer_nxt;
            r_paused     <= w_paused_nxt;
            r_pos        <= w_pos_nxt;
            r_led        <= w_led_nxt;
            r_step_pulse <= w_step;
        end
    end

    assign led        = r_led;
    assign pos        = r_pos;
    assign step_pulse = r_step_pulse;
    assign paused     = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_led_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_led_step_sequencer                                             |
// | Brief  : Scoreboard bench with a press/timer reference model.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_led_step_sequencer;
    import led_seq_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int P  = 8;
    localparam int PW = 2;
    // Edge at which a level driven just after edge n first affects outputs.
    localparam int LAT = 4 + D;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [N-1:0]  btn_n = '1;
    logic [1:0]    mode  = 2'b00;
    logic [N-1:0]  led;
    logic [PW-1:0] pos;
    logic          step_pulse;
    logic          paused;

    led_step_sequencer #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D),
        .AUTO_PERIOD     (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .mode       (mode),
        .led        (led),
        .pos        (pos),
        .step_pulse (step_pulse),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int t;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_pos  = 0;
    logic [1:0] m_mode = MODE_STEP_OWN;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every step_pulse consumes one scoreboard entry.
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && step_pulse) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: got step to pos %0d at cycle %0d, expected none", pos, cyc);
            end else begin
                m_e = sb.pop_front();
                chk("step_cycle", cyc, m_e.t);
                chk("step_pos", int'(pos), m_e.p);
                chk("step_led", int'(led), 1 << m_e.p);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int fwd(input int p);
        return (p + 1) % N;
    endfunction

    function automatic int rev(input int p);
        return (p + N - 1) % N;
    endfunction

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic set_step_mode(input logic [1:0] m);
        if (m != m_mode) begin
            mode   = m;
            m_mode = m;
            tick(2);
        end
    endtask

    // One button episode in a step mode; the model decides whether it steps.
    task automatic do_press(input logic [N-1:0] mask, input int hold);
        int n;
        bit acc;
        n   = cyc;
        acc = (hold >= D) && ((m_mode == MODE_STEP_ANY) ? (mask != '0) : mask[m_pos]);
        if (acc) begin
            m_pos = fwd(m_pos);
            sb.push_back('{m_pos, n + LAT});
        end
        btn_n = ~mask;
        tick(hold);
        btn_n = '1;
        tick(2 * D + 4);
    endtask

    task automatic pulse_btn(input int hold);
        btn_n[$urandom_range(0, N - 1)] = 1'b0;
        tick(hold);
        btn_n = '1;
    endtask

    // variant 0: free run; 1: pause and leave mode while paused; 2: pause and resume.
    task automatic run_auto(input logic [1:0] m, input int variant);
        int n, ec, np, tp, nr, tr, nm, cnt;
        n  = cyc;
        ec = n + 1;
        np = n + $urandom_range(2, P + 5);
        tp = np + LAT;
        nr = np + (D + 1) + 2 * D + 6 + $urandom_range(0, P);
        tr = (variant == 2) ? nr + LAT : 32'h3fff_ffff;
        if (variant == 0)      nm = n + 4 * P + $urandom_range(1, P - 1);
        else if (variant == 1) nm = tp + $urandom_range(2, P);
        else                   nm = tr + 2 + $urandom_range(0, 2 * P);
        cnt = 0;
        for (int e = ec + 1; e < nm + 1; e++) begin
            if (variant != 0 && e > tp && e <= tr) continue;
            cnt++;
            if (cnt == P) begin
                cnt   = 0;
                m_pos = (m == MODE_AUTO_FWD) ? fwd(m_pos) : rev(m_pos);
                sb.push_back('{m_pos, e});
            end
        end
        mode   = m;
        m_mode = m;
        if (variant != 0) begin
            wait_to(np);
            pulse_btn(D + 1);
            wait_to(tp + 1);
            chk("paused_set", int'(paused), 1);
            if (variant == 2) begin
                wait_to(nr);
                pulse_btn(D + 1);
                wait_to(tr + 1);
                chk("paused_clr", int'(paused), 0);
            end
        end
        wait_to(nm);
        mode   = MODE_STEP_OWN;
        m_mode = MODE_STEP_OWN;
        tick(1);
        chk("mode_chg_paused", int'(paused), 0);
        chk("mode_chg_pos", int'(pos), m_pos);
        chk("mode_chg_nostep", int'(step_pulse), 0);
        tick(2 * D + 6);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_led"}, int'(led), 1);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_step"}, int'(step_pulse), 0);
        chk({tag, "_paused"}, int'(paused), 0);
    endtask

    initial begin
        int n;
        logic [N-1:0] msk;
        tick(3);
        check_reset_state("reset");
        rst = 1'b0;
        tick(2);

        // Held press on the current channel; glitch and wrong-channel presses.
        do_press(4'b0001, D + 2);
        do_press(4'b0100, D + 2);
        chk("own_ignore_pos", int'(pos), 1);
        do_press(4'b0010, D - 1);
        chk("glitch_pos", int'(pos), 1);
        do_press(4'b0010, D);

        set_step_mode(MODE_STEP_ANY);
        do_press(4'b1001, D + 1);
        while (m_pos != N - 1) do_press(4'b0001, D + 1);
        do_press(4'b0100, D + 1);
        chk("wrap_pos", int'(pos), 0);

        for (int i = 0; i < 30; i++) begin
            set_step_mode(($urandom_range(0, 1) != 0) ? MODE_STEP_ANY : MODE_STEP_OWN);
            msk = N'($urandom_range(1, (1 << N) - 1));
            do_press(msk, $urandom_range(1, D + 3));
        end

        set_step_mode(MODE_STEP_ANY);
        while (m_pos != 0) do_press(4'b0010, D + 1);
        set_step_mode(MODE_STEP_OWN);
        run_auto(MODE_AUTO_REV, 0);
        run_auto(MODE_AUTO_REV, 2);
        run_auto(MODE_AUTO_FWD, 1);
        run_auto(MODE_AUTO_FWD, 0);
        for (int i = 0; i < 3; i++) begin
            run_auto(($urandom_range(0, 1) != 0) ? MODE_AUTO_FWD : MODE_AUTO_REV,
                     $urandom_range(0, 2));
        end

        // Reset during a debounce count; the held button must re-qualify.
        set_step_mode(MODE_STEP_ANY);
        if (m_pos == 0) do_press(4'b0001, D + 1);
        set_step_mode(MODE_STEP_OWN);
        btn_n[0] = 1'b0;
        tick(3);
        #2 rst = 1'b1;
        #1 check_reset_state("rst_debounce");
        chk("rst_debounce_sb", sb.size(), 0);
        tick(2);
        rst   = 1'b0;
        n     = cyc;
        m_pos = 1;
        sb.push_back('{1, n + LAT});
        tick(D + 3);
        btn_n = '1;
        tick(2 * D + 6);

        // Reset during auto-run; first step lands one period after release.
        mode   = MODE_AUTO_FWD;
        m_mode = MODE_AUTO_FWD;
        tick(5);
        #2 rst = 1'b1;
        #1 check_reset_state("rst_auto");
        tick(2);
        rst   = 1'b0;
        n     = cyc;
        m_pos = 2;
        sb.push_back('{1, n + P});
        sb.push_back('{2, n + 2 * P});
        wait_to(n + 2 * P + 3);
        mode   = MODE_STEP_OWN;
        m_mode = MODE_STEP_OWN;
        tick(1);
        chk("rst_auto_pos", int'(pos), m_pos);

        tick(10);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_step_sequencer.md
# led_step_sequencer

Parametrised one-hot LED sequencer driven by N active-low push-buttons. It generalises the fixed 4-LED button-stepped state machine in four ways: any channel count, per-button synchronisation and debounce, single-cycle press events, and four selectable stepping modes including timed auto-run with pause. It sits between the board button/LED pins and the internal oscillator clock, and exports its position for other blocks.

## Interface
- N_CH, 4: number of buttons/LEDs; ≥2.
- DEBOUNCE_CYCLES, 60000: consecutive stable cycles required to accept a button level (10 ms at 6 MHz); ≥2.
- AUTO_PERIOD, 3000000: cycles per step in auto modes (0.5 s at 6 MHz); ≥2.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- btn_n  in  N_CH  raw button pins, active-low, asynchronous to clk.
- mode  in  2  00 STEP_OWN, 01 STEP_ANY, 10 AUTO_FWD, 11 AUTO_REV; quasi-static, sampled every cycle.
- led  out  N_CH  registered one-hot, led[pos]=1.
- pos  out  $clog2(N_CH)  registered current position.
- step_pulse  out  1  registered, high for exactly the one cycle in which pos/led show a new value.
- paused  out  1  registered auto-mode pause flag.

## Operation
- Reset: pos=0, led=1 (bit 0 only), step_pulse=0, paused=0, auto timer=0, all debouncers stable=1 (released), sync flops=1, counters=0.
- Per button: 2-flop synchroniser → debounce counter. The counter increments while the synchronised level differs from stable, and clears to 0 whenever the two are equal. When the counter would reach DEBOUNCE_CYCLES, stable flips and the counter clears. press[i] is a registered one-cycle pulse on each stable 1→0 transition. Releases generate nothing.
- STEP_OWN: press[pos] advances pos forward. Presses on other channels are ignored.
- STEP_ANY: any press advances pos forward. Several presses in the same cycle give one step.
- AUTO_FWD / AUTO_REV:
  - The timer counts 0..AUTO_PERIOD-1 while paused=0. At AUTO_PERIOD-1 it wraps to 0 and pos steps forward or reverse.
  - Any press toggles paused; simultaneous presses toggle once.
  - While paused, the timer holds its value.
- Wrap: forward N_CH-1 → 0; reverse 0 → N_CH-1.
- Mode change (mode differs from the previous cycle's registered mode):
  - timer cleared to 0; paused cleared; pos held; no step in that cycle.
  - A press in the same cycle is discarded.
- In STEP modes the timer is held at 0 and paused=0.
- Reset mid-operation: every register returns to its reset value immediately. An in-progress debounce is abandoned, so a button still held after reset releases must be re-qualified as a press. It yields a press once its stable level reaches 0 from the reset value of 1.

## Timing
- A btn_n falling edge first captured at edge E0 reaches the synchroniser output at E1.
- stable flips at E1+DEBOUNCE_CYCLES; press pulses at E2+DEBOUNCE_CYCLES.
- pos, led and step_pulse update at E3+DEBOUNCE_CYCLES.
- Glitch shorter than DEBOUNCE_CYCLES: no press event.
- Auto step: with no pause and no mode change, steps are spaced exactly AUTO_PERIOD cycles. The first step occurs AUTO_PERIOD cycles after entering the mode or after reset.
- Pause toggle takes effect on the edge after the press pulse.

## Structure
- Package led_seq_pkg: mode encodings MODE_STEP_OWN/STEP_ANY/AUTO_FWD/AUTO_REV and a 2-bit mode typedef.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_n, stable, press), instantiated N_CH times by generate.
- The top holds the mode register, auto timer, pos/led/step_pulse/paused registers.

## Test plan
Bench parameters: N_CH=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
- Reset, mode=00, hold btn_n[0] low from E0 → led 0001→0010 at E7, step_pulse high only at E7; pressing btn 2 while pos=1 → no change.
- btn_n[1] low for 3 cycles then high → no press, led unchanged; held 4+ cycles → step.
- mode=01, btn 0 and btn 3 pressed in the same cycle → exactly one step; from pos=3 a press → pos=0 (wrap).
- mode=11 from pos=0 → pos=3 after 8 cycles, then 2, 1, 0 at 8-cycle spacing; press mid-period → paused=1, timer frozen; second press resumes with the remaining cycles.
- mode 10→00 mid-period → pos held, timer=0, paused=0, no step_pulse.
- rst asserted during a debounce count and during auto-run → led=0001, pos=0, step_pulse=0 asynchronously; a held button re-qualifies after release of rst.
